// File: rtl/adder_word_sequencer.sv
// adder_word_sequencer: feeds one wide add job through a WIDTH-bit adder one slice at
// a time, LSB slice first, chaining the adder's carry-out into the next slice's
// carry-in and collecting the sum slices into one wide result.
// Optional feature macro: ADDSEQ_OVF_EN adds the out_ovf two's-complement overflow flag.
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// ISSUE | current slice on add_a/add_b/add_cin (captured here when the adder is combinational)
// WAIT  | registered adder only: inputs held, sum/cout captured on this edge
// DONE  | result valid, held until out_ready
module adder_word_sequencer #(
  parameter int WIDTH         = 4,
  parameter int N_WORDS       = 2,
  parameter int ADDER_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_WORDS*WIDTH-1:0]   in_a,
  input  logic [N_WORDS*WIDTH-1:0]   in_b,
  input  logic                       in_cin,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_WORDS*WIDTH-1:0]   out_sum,
  output logic                       out_cout
`ifdef ADDSEQ_OVF_EN
  ,
  output logic                       out_ovf
`endif
);

  localparam int TW    = N_WORDS * WIDTH;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TW-1:0]      a_q, a_d;
  logic [TW-1:0]      b_q, b_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic [TW-1:0]      out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               capture;
`ifdef ADDSEQ_OVF_EN
  logic               out_ovf_q, out_ovf_d;
`endif

  // Next-state, slice sequencing and result collection.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    capture    = 1'b0;
`ifdef ADDSEQ_OVF_EN
    out_ovf_d  = out_ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          idx_d     = '0;
          add_a_d   = in_a[WIDTH-1:0];
          add_b_d   = in_b[WIDTH-1:0];
          add_cin_d = in_cin;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (ADDER_LATENCY == 0) capture = 1'b1;
        else                    state_d = WAIT;
      end
      WAIT: capture = 1'b1;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // add_cin is only advanced for a following slice so it keeps the last
    // driven carry-in while the result sits in DONE.
    if (capture) begin
      out_sum_d[idx_q*WIDTH +: WIDTH] = add_sum;
      if (idx_q == IDX_W'(N_WORDS - 1)) begin
        out_cout_d = add_cout;
        state_d    = DONE;
`ifdef ADDSEQ_OVF_EN
        out_ovf_d  = (a_q[TW-1] == b_q[TW-1]) && (add_sum[WIDTH-1] != a_q[TW-1]);
`endif
      end else begin
        idx_d     = idx_q + IDX_W'(1);
        add_a_d   = a_q[idx_d*WIDTH +: WIDTH];
        add_b_d   = b_q[idx_d*WIDTH +: WIDTH];
        add_cin_d = add_cout;
        state_d   = ISSUE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
    end
  end

`ifdef ADDSEQ_OVF_EN
  // Overflow flag register, computed once at the final slice capture.
  always_ff @(posedge clk) begin
    if (rst) out_ovf_q <= 1'b0;
    else     out_ovf_q <= out_ovf_d;
  end

  assign out_ovf = out_ovf_q;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed bench for adder_word_sequencer (WIDTH=4, N_WORDS=2). Main instance uses a
// registered adder model (latency 1); a second instance uses a combinational adder.
module tb_adder_word_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_cin;
  logic [7:0] in_a, in_b;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       out_valid, out_ready, out_cout;
  logic [7:0] out_sum;
`ifdef ADDSEQ_OVF_EN
  logic       out_ovf;
`endif

  logic       in_valid0, in_ready0, out_valid0, out_ready0, out_cout0;
  logic [3:0] add_a0, add_b0, add_sum0;
  logic       add_cin0, add_cout0;
  logic [7:0] out_sum0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  adder_word_sequencer #(.WIDTH(4), .N_WORDS(2), .ADDER_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDSEQ_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  adder_word_sequencer #(.WIDTH(4), .N_WORDS(2), .ADDER_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
    .add_sum(add_sum0), .add_cout(add_cout0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(out_sum0), .out_cout(out_cout0)
`ifdef ADDSEQ_OVF_EN
    , .out_ovf()
`endif
  );

  // registered 4-bit adder model
  always @(posedge clk) {add_cout, add_sum} <= 5'(add_a) + 5'(add_b) + 5'(add_cin);

  // combinational 4-bit adder model
  assign {add_cout0, add_sum0} = 5'(add_a0) + 5'(add_b0) + 5'(add_cin0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a job, wait (bounded) for in_ready, pass through the accepting edge
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // count edges after the accepting edge until out_valid (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int extra;
    logic [7:0] ja [3] = '{8'h12, 8'hF0, 8'h5A};
    logic [7:0] jb [3] = '{8'h34, 8'h20, 8'hA5};
    logic       jc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] js [3] = '{8'h46, 8'h10, 8'h00};
    logic       jo [3] = '{1'b0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // FF + 00 + 1: carry ripples into slice 1, then backpressure
    accept(8'hFF, 8'h00, 1'b1);
    chk("s0_add_a", add_a, 4'hF);
    chk("s0_add_cin", add_cin, 1);
    tick(); tick();
    chk("s1_add_a", add_a, 4'hF);
    chk("s1_add_b", add_b, 4'h0);
    chk("s1_add_cin", add_cin, 1);
    wait_valid(lat);
    chk("ripple_lat_rest", lat, 2);
    chk("ripple_sum", out_sum, 8'h00);
    chk("ripple_cout", out_cout, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 8'h00);
      chk("bp_out_cout", out_cout, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_add_cin_hold", add_cin, 1);
    end
    release_result();

    // 99 + AA + 1, operands scrambled after accept
    accept(8'h99, 8'hAA, 1'b1);
    in_a = 8'h3C; in_b = 8'hC3; in_cin = 1'b0;
    wait_valid(lat);
    chk("j1_latency", lat, 4);
    chk("j1_sum", out_sum, 8'h44);
    chk("j1_cout", out_cout, 1);
    chk("j1_in_ready", in_ready, 0);
    release_result();

    // reset during WAIT of slice 0
    accept(8'h0F, 8'h01, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_sum", out_sum, 0);
    chk("abort_out_cout", out_cout, 0);
    chk("abort_add_a", add_a, 0);
    tick(); tick();
    chk("abort_no_output", out_valid, 0);
    accept(8'h01, 8'h01, 1'b0);
    wait_valid(lat);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_sum", out_sum, 8'h02);
    chk("post_abort_cout", out_cout, 0);
    release_result();

    // three back-to-back jobs, in_valid held high, out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_a = ja[j]; in_b = jb[j]; in_cin = jc[j];
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      chk("b2b_ready", in_ready, 1);
      tick();
      wait_valid(lat);
      chk("b2b_latency", lat, 4);
      chk("b2b_sum", out_sum, js[j]);
      chk("b2b_cout", out_cout, jo[j]);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_released", out_valid, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) extra++;
    end
    chk("b2b_no_extra", extra, 0);
    out_ready = 1'b0;

    // combinational-adder instance
    in_a = 8'h99; in_b = 8'hAA; in_cin = 1'b1; in_valid0 = 1'b1;
    chk("lat0_ready", in_ready0, 1);
    tick();
    in_valid0 = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !out_valid0; i++) begin
      tick();
      lat++;
    end
    chk("lat0_latency", lat, 2);
    chk("lat0_sum", out_sum0, 8'h44);
    chk("lat0_cout", out_cout0, 1);
    tick();
    chk("lat0_released", out_valid0, 0);

`ifdef ADDSEQ_OVF_EN
    accept(8'h7F, 8'h01, 1'b0);
    wait_valid(lat);
    chk("ovf1_sum", out_sum, 8'h80);
    chk("ovf1_flag", out_ovf, 1);
    release_result();
    accept(8'h10, 8'h20, 1'b0);
    wait_valid(lat);
    chk("ovf0_sum", out_sum, 8'h30);
    chk("ovf0_flag", out_ovf, 0);
    release_result();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
